// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard Wishbone slave: register map,
// STATUS bit positions, receiver state encoding and PS/2 frame geometry.
package kbd_pkg;

  // Register select decoded from ADDR[2]
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register layout
  localparam int ST_OVERFLOW   = 0;
  localparam int ST_FRAME_ERR  = 1;
  localparam int ST_PARITY_ERR = 2;
  localparam int ST_COUNT_LSB  = 8;

  // Start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input synchronizers, falling-edge
// detect, frame FSM and inactivity timeout. Emits a one-cycle rx_valid
// strobe with rx_byte for each good frame, plus error pulses.
// Optional build macro: KBD_PARITY_CHECK_EN enables odd-parity checking.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err_p,
  output logic       parity_err_p
);

  localparam int TO_W       = $clog2(TIMEOUT + 1);
  localparam int SHIFT_BITS = FRAME_BITS - 1;  // everything after the start bit

  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic       ps2_clk_s;
  logic       ps2_data_s;
  logic       clk_prev_reg;
  logic       fall;

  logic [SHIFT_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  rx_state_t             state_reg;
  rx_state_t             state_next;
  logic                  timeout_hit;
  logic                  stop_bit;
  logic                  par_bit;

  assign line_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [1:0] chain_reg;
      // Two-flop synchronizer, idles high like the PS/2 bus
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= 2'b11;
        end else begin
          chain_reg <= {chain_reg[0], line_raw[gi]};
        end
      end
      assign line_sync[gi] = chain_reg[1];
    end
  endgenerate

  assign ps2_clk_s   = line_sync[0];
  assign ps2_data_s  = line_sync[1];
  assign fall        = clk_prev_reg & ~ps2_clk_s;
  assign timeout_hit = (state_reg == RX_SHIFT) && (to_cnt_reg == TO_W'(TIMEOUT));
  assign rx_byte     = shift_reg[7:0];
  assign par_bit     = shift_reg[8];
  assign stop_bit    = shift_reg[9];

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start bit opens a frame, ten more edges close it
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RX_IDLE: begin
        if (fall && !ps2_data_s) state_next = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (fall && bit_cnt_reg == 4'(SHIFT_BITS - 1)) state_next = RX_CHECK;
        else if (!fall && timeout_hit)                  state_next = RX_IDLE;
      end
      RX_CHECK: state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Edge history, bit shifter and inactivity counter
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_reg <= 1'b1;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
    end else begin
      clk_prev_reg <= ps2_clk_s;
      if (fall) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg != TO_W'(TIMEOUT)) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (state_reg == RX_IDLE) begin
        bit_cnt_reg <= '0;
      end else if (state_reg == RX_SHIFT && fall) begin
        shift_reg   <= {ps2_data_s, shift_reg[SHIFT_BITS-1:1]};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

`ifdef KBD_PARITY_CHECK_EN
  // Frame verdict: stop bit and odd parity must both be right
  always_comb begin
    rx_valid     = 1'b0;
    frame_err_p  = 1'b0;
    parity_err_p = 1'b0;
    if (state_reg == RX_CHECK) begin
      frame_err_p  = ~stop_bit;
      parity_err_p = stop_bit & ~odd_parity_ok(rx_byte, par_bit);
      rx_valid     = stop_bit & odd_parity_ok(rx_byte, par_bit);
    end else if (timeout_hit && !fall) begin
      frame_err_p = 1'b1;
    end
  end
`else
  // Parity bit is captured but deliberately not examined in this build
  logic unused_par;
  assign unused_par = par_bit;

  // Frame verdict: only the stop bit decides
  always_comb begin
    rx_valid     = 1'b0;
    frame_err_p  = 1'b0;
    parity_err_p = 1'b0;
    if (state_reg == RX_CHECK) begin
      frame_err_p = ~stop_bit;
      rx_valid    = stop_bit;
    end else if (timeout_hit && !fall) begin
      frame_err_p = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/wb_ps2_keyboard.sv
// Wishbone keyboard slave: scan-code FIFO, sticky error flags and the
// DATA/STATUS register pair behind a registered single-cycle ACK.
// Optional build macro: KBD_PARITY_CHECK_EN enables the parity_err flag.
module wb_ps2_keyboard
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err_p;
  logic       parity_err_p;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .frame_err_p  (frame_err_p),
    .parity_err_p (parity_err_p)
  );

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic             frame_err_reg;
  logic             parity_err_reg;
  logic             ack_reg;
  logic [31:0]      dat_o_reg;

  logic        access;
  logic        is_status;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        flush;
  logic        push_ok;
  logic        ovf_set;
  logic [2:0]  clr;
  logic [31:0] rd_data;
  logic        unused_bits;

  // Side effects commit only on the edge that raises ACK
  assign access     = STB & ~ack_reg;
  assign is_status  = (ADDR[2] == REG_STATUS);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop        = access & ~WE & ~is_status & ~fifo_empty;
  assign flush      = access & WE & ~is_status;
  assign clr        = (access & WE & is_status) ? DAT_I[2:0] : 3'b000;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok    = rx_valid & ~flush & (~fifo_full | pop);
  assign ovf_set    = rx_valid & ~flush & fifo_full & ~pop;
  assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:2], parity_err_p};

  assign ACK   = ack_reg;
  assign DAT_O = dat_o_reg;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // FIFO storage write port, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= rx_byte;
    end
  end

  // Pointer and count bookkeeping; flush empties the FIFO
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Sticky flags: a new event outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      overflow_reg  <= (overflow_reg & ~clr[ST_OVERFLOW]) | ovf_set;
      frame_err_reg <= (frame_err_reg & ~clr[ST_FRAME_ERR]) | frame_err_p;
`ifdef KBD_PARITY_CHECK_EN
      parity_err_reg <= (parity_err_reg & ~clr[ST_PARITY_ERR]) | parity_err_p;
`else
      parity_err_reg <= 1'b0;
`endif
    end
  end

  // Read mux: DATA shows head with valid bit, STATUS shows count and flags
  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[ST_COUNT_LSB +: 8] = 8'(count_reg);
      rd_data[ST_PARITY_ERR]     = parity_err_reg;
      rd_data[ST_FRAME_ERR]      = frame_err_reg;
      rd_data[ST_OVERFLOW]       = overflow_reg;
    end else if (!fifo_empty) begin
      rd_data[8]   = 1'b1;
      rd_data[7:0] = fifo_mem[rd_ptr_reg];
    end
  end

  // Registered ACK and read data, valid together for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
    end else begin
      ack_reg   <= STB & ~ack_reg;
      dat_o_reg <= (access & ~WE) ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// Self-checking bench for wb_ps2_keyboard with a queue-based reference model.
module tb_wb_ps2_keyboard;

  localparam int DEPTH = 16;
  localparam int TO    = 300;
  localparam int HALF  = 20;
  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        ps2_clk;
  logic        ps2_data;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_ovf, m_ferr, m_perr;

  wb_ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .STB      (STB),
    .WE       (WE),
    .ADDR     (ADDR),
    .DAT_I    (DAT_I),
    .DAT_O    (DAT_O),
    .ACK      (ACK),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic good_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic par, input logic stop);
    if (!stop)                                   m_ferr = 1'b1;
    else if (PAR_EN && ((^{b, par}) == 1'b0))    m_perr = 1'b1;
    else if (m_q.size() == DEPTH)                m_ovf  = 1'b1;
    else                                         m_q.push_back(b);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[15:8] = 8'(m_q.size());
    s[2] = m_perr; s[1] = m_ferr; s[0] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] model_pop();
    logic [31:0] v;
    v = '0;
    if (m_q.size() > 0) begin
      v[8] = 1'b1;
      v[7:0] = m_q.pop_front();
    end
    return v;
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    @(negedge clk); ps2_data = 1'b1;
    repeat (8) @(negedge clk);
    $display("ps2 frame byte=%h par=%b stop=%b", b, par, stop);
    model_rx(b, par, stop);
  endtask

  task automatic wb_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    int n;
    got = 0; n = 0;
    @(negedge clk);
    STB = 1'b1; WE = we; ADDR = addr; DAT_I = wdata;
    while (!got && n < 8) begin
      @(negedge clk); n++;
      if (ACK === 1'b1) got = 1;
    end
    rdata = DAT_O;
    STB = 1'b0; WE = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL wb_ack_timeout got ACK=%b want 1", ACK);
    end
    $display("wb we=%0d addr=%h wdata=%h rdata=%h", we, addr, wdata, rdata);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ACK !== 1'b0) $display("FAIL reset_ack got %b want 0", ACK); else passes++;
    checks++; if (DAT_O !== 32'h0) $display("FAIL reset_dat got %h want 0", DAT_O); else passes++;
    reset = 1'b0;
    model_reset();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h0) $display("FAIL reset_status got %h want 0", r); else passes++;
    wb_access(1'b0, A_DATA, 32'h0, r);
    checks++; if (r !== 32'h0) $display("FAIL reset_data got %h want 0", r); else passes++;
  endtask

  task automatic test_single_key();
    logic [31:0] r, e;
    send_frame(8'h1C, 1'b0, 1'b1);
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h100) $display("FAIL single_status got %h want %h", r, 32'h100); else passes++;
    wb_access(1'b0, A_DATA, 32'h0, r);
    e = model_pop();
    checks++; if (r !== 32'h11C || r !== e) $display("FAIL single_data got %h want %h", r, e); else passes++;
    wb_access(1'b0, A_DATA, 32'h0, r);
    checks++; if (r !== 32'h0) $display("FAIL single_empty got %h want 0", r); else passes++;
  endtask

  task automatic test_parity();
    logic [31:0] r, e;
    send_frame(8'h1C, 1'b1, 1'b1);
    e = exp_status();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== e) $display("FAIL parity_status got %h want %h", r, e); else passes++;
    wb_access(1'b1, A_STATUS, 32'h4, r);
    m_perr = 1'b0;
    e = exp_status();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== e) $display("FAIL parity_clear got %h want %h", r, e); else passes++;
    while (m_q.size() > 0) begin
      e = model_pop();
      wb_access(1'b0, A_DATA, 32'h0, r);
      checks++; if (r !== e) $display("FAIL parity_drain got %h want %h", r, e); else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r, e;
    for (int i = 1; i <= 17; i++) send_frame(8'(i), good_par(8'(i)), 1'b1);
    e = exp_status();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h1001 || r !== e) $display("FAIL ovf_status got %h want %h", r, e); else passes++;
    for (int i = 1; i <= 16; i++) begin
      e = model_pop();
      wb_access(1'b0, A_DATA, 32'h0, r);
      checks++; if (r !== e) $display("FAIL ovf_data%0d got %h want %h", i, r, e); else passes++;
    end
    wb_access(1'b1, A_STATUS, 32'h1, r);
    m_ovf = 1'b0;
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== exp_status()) $display("FAIL ovf_clear got %h want %h", r, exp_status()); else passes++;
  endtask

  task automatic test_timeout();
    logic [31:0] r, e;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    @(negedge clk); ps2_data = 1'b1;
    repeat (TO + 10 + HALF) @(negedge clk);
    m_ferr = 1'b1;
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h2) $display("FAIL timeout_status got %h want 2", r); else passes++;
    wb_access(1'b1, A_STATUS, 32'h2, r);
    m_ferr = 1'b0;
    send_frame(8'h2A, good_par(8'h2A), 1'b1);
    e = model_pop();
    wb_access(1'b0, A_DATA, 32'h0, r);
    checks++; if (r !== e || r !== 32'h12A) $display("FAIL timeout_next got %h want %h", r, e); else passes++;
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== exp_status()) $display("FAIL timeout_clear got %h want %h", r, exp_status()); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] r, e;
    logic [7:0] b;
    logic par, stop;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      par = ($urandom_range(0, 7) == 0) ? ~good_par(b) : good_par(b);
      send_frame(b, par, stop);
      if ($urandom_range(0, 2) == 0) begin
        e = model_pop();
        wb_access(1'b0, A_DATA, 32'h0, r);
        checks++; if (r !== e) $display("FAIL rand_data%0d got %h want %h", n, r, e); else passes++;
      end
    end
    e = exp_status();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== e) $display("FAIL rand_status got %h want %h", r, e); else passes++;
    wb_access(1'b1, A_STATUS, 32'h7, r);
    m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    e = exp_status();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== e) $display("FAIL rand_clear got %h want %h", r, e); else passes++;
    while (m_q.size() > 0) begin
      e = model_pop();
      wb_access(1'b0, A_DATA, 32'h0, r);
      checks++; if (r !== e) $display("FAIL rand_drain got %h want %h", r, e); else passes++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, good_par(b), 1'b1);
    end
    wb_access(1'b1, A_DATA, 32'hFFFF_FFFF, r);
    m_q.delete();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== exp_status()) $display("FAIL flush_status got %h want %h", r, exp_status()); else passes++;
    wb_access(1'b0, A_DATA, 32'h0, r);
    checks++; if (r !== 32'h0) $display("FAIL flush_data got %h want 0", r); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int acks;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, good_par(b), 1'b1);
    end
    acks = 0;
    @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = A_DATA;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ACK === 1'b1) begin
        acks++;
        e = model_pop();
        $display("wb b2b read rdata=%h", DAT_O);
        checks++; if (DAT_O !== e) $display("FAIL b2b_data%0d got %h want %h", acks, DAT_O, e); else passes++;
      end
    end
    STB = 1'b0;
    checks++; if (acks !== 3) $display("FAIL b2b_acks got %0d want 3", acks); else passes++;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r, e;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'hA0 + i), good_par(8'(8'hA0 + i)), 1'b1);
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h1000) $display("FAIL full_status got %h want %h", r, 32'h1000); else passes++;
    b = 8'h77;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good_par(b));
    @(negedge clk); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    STB = 1'b1; WE = 1'b0; ADDR = A_DATA;
    @(negedge clk);
    e = model_pop();
    m_q.push_back(b);
    checks++; if (ACK !== 1'b1) $display("FAIL pp_ack got %b want 1", ACK); else passes++;
    checks++; if (DAT_O !== e) $display("FAIL pp_data got %h want %h", DAT_O, e); else passes++;
    $display("wb pushpop read rdata=%h", DAT_O);
    STB = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== exp_status() || r !== 32'h1000) $display("FAIL pp_status got %h want %h", r, exp_status()); else passes++;
    while (m_q.size() > 0) begin
      e = model_pop();
      wb_access(1'b0, A_DATA, 32'h0, r);
      checks++; if (r !== e) $display("FAIL pp_drain got %h want %h", r, e); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e;
    send_frame(8'h33, good_par(8'h33), 1'b1);
    send_frame(8'h44, good_par(8'h44), 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    STB = 1'b1; WE = 1'b0; ADDR = A_STATUS; reset = 1'b1;
    @(negedge clk);
    checks++; if (ACK !== 1'b0) $display("FAIL rmid_ack got %b want 0", ACK); else passes++;
    checks++; if (DAT_O !== 32'h0) $display("FAIL rmid_dat got %h want 0", DAT_O); else passes++;
    reset = 1'b0; STB = 1'b0;
    model_reset();
    wb_access(1'b0, A_STATUS, 32'h0, r);
    checks++; if (r !== 32'h0) $display("FAIL rmid_status got %h want 0", r); else passes++;
    send_frame(8'h55, good_par(8'h55), 1'b1);
    e = model_pop();
    wb_access(1'b0, A_DATA, 32'h0, r);
    checks++; if (r !== e || r !== 32'h155) $display("FAIL rmid_next got %h want %h", r, e); else passes++;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; STB = 1'b0; WE = 1'b0;
    ADDR = '0; DAT_I = '0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    test_reset();
    test_single_key();
    test_parity();
    test_overflow();
    test_timeout();
    test_random();
    test_flush();
    test_back_to_back();
    test_push_pop_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_ps2_keyboard.md
# wb_ps2_keyboard

Wishbone slave that receives scan codes from a PS/2 keyboard, buffers them in a byte FIFO and answers CPU reads and writes on the keyboard slot of the system bus (slave index 3, `Keyboard_STB`/`Keyboard_ACK`/`Keyboard_DAT_O`). It is the bus-responder end of the CPU's Wishbone master interface. It deserializes PS/2 device-to-host frames, checks them and exposes a data/status register pair.

## Interface
- `FIFO_DEPTH`, default 16: scan-code FIFO entries; a power of two, at least 2.
- `TIMEOUT`, default 5000: clk cycles with no PS/2 falling edge before a partial frame is discarded.
- `clk` in 1: system clock. There is only this one clock.
- `reset` in 1: synchronous reset, active-high.
- `STB` in 1: Wishbone strobe for this slave.
- `WE` in 1: write enable.
- `ADDR` in 32: byte address. Only bit 2 is decoded (0 = DATA, 1 = STATUS).
- `DAT_I` in 32: write data.
- `DAT_O` out 32: read data. Reset value 0.
- `ACK` out 1: acknowledge. Reset value 0.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.

## Operation
- **Synchronizers:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A falling edge is detected on the synchronized clock (previous = 1, current = 0).
- **Receiver states:** IDLE, SHIFT, CHECK.
  - IDLE to SHIFT: on a falling edge with data = 0 (start bit).
  - SHIFT: captures 10 more bits on successive falling edges, in this order: 8 data bits LSB first, odd parity, stop.
  - CHECK (one cycle): the frame is good if stop = 1 and the parity check passes. A good byte is pushed to the FIFO. CHECK always returns to IDLE.
  - Any falling edge in IDLE with data = 1 is ignored.
- **Timeout:** the counter clears on every falling edge. If it reaches `TIMEOUT` while in SHIFT, the receiver returns to IDLE, drops the partial frame and sets `frame_err`.
- **Bad stop bit:** sets `frame_err`; the byte is dropped.
- **FIFO full:** a push to a full FIFO drops the new byte, sets `overflow` and leaves the FIFO contents unchanged.
- **DATA read (ADDR[2] = 0):** returns `{23'b0, valid, byte}`.
  - `valid` = FIFO not empty; `byte` = head entry.
  - If `valid`, the head is popped when ACK is asserted.
  - An empty read returns 0 and changes nothing.
- **STATUS read (ADDR[2] = 1):** returns `{16'b0, count[7:0], 5'b0, parity_err, frame_err, overflow}`.
- **STATUS write:** each of bits [2:0] written as 1 clears the corresponding flag (write-1-to-clear). Bits [31:3] are ignored.
- **DATA write:** flushes the FIFO (count becomes 0). `DAT_I` is ignored.
- **Simultaneous push and pop in one cycle:** both take effect and count is unchanged. When the FIFO is full, a pop and a push in the same cycle both succeed with no overflow.
- **Simultaneous flag set and write-1-to-clear in one cycle:** set wins.
- **Pointers:** log2(`FIFO_DEPTH`)-bit read and write pointers that wrap modulo `FIFO_DEPTH`. Count is log2(`FIFO_DEPTH`)+1 bits wide and is zero-extended into `count[7:0]`.

## Timing
- **ACK rule:** `ACK` is registered, `ACK <= STB & ~ACK`.
  - ACK asserts one cycle after STB is sampled high and lasts exactly one cycle.
  - If STB is held high, ACK repeats every second cycle and each ACK is a separate access.
- **Read data and side effects:** `DAT_O` is registered in the same cycle that ACK is generated, so it is valid while ACK is high. All side effects (pop, clear, flush) commit on the clock edge that raises ACK.
- **Receive latency:** a received byte is readable (`valid` = 1) 2 clk cycles after the synchronized falling edge of the stop bit: one cycle for CHECK, one for the FIFO write. Synchronizer delay adds 2 more cycles.
- **Reset (synchronous, any time, including mid-frame or mid-access):**
  - receiver goes to IDLE, timeout counter = 0;
  - FIFO pointers = 0, all flags = 0;
  - `ACK` = 0, `DAT_O` = 0;
  - synchronizer flops = 1 (PS/2 idle level).

## Configuration
- `KBD_PARITY_CHECK_EN` defined:
  - odd parity is checked in CHECK;
  - a mismatch drops the byte and sets `parity_err`.
- Not defined:
  - the parity bit is shifted in but ignored;
  - `parity_err` is held at 0;
  - STATUS bit 2 always reads 0.

## Structure
- **Shared package `kbd_pkg`:**
  - register offsets DATA = 0 and STATUS = 1 (ADDR[2]);
  - STATUS bit positions;
  - receiver state encoding (IDLE, SHIFT, CHECK);
  - PS/2 frame length of 11 bits.
- **Sub-module `ps2_rx`:** contains the synchronizers, edge detect, the frame FSM and the timeout counter. It outputs a one-cycle `rx_valid` strobe with `rx_byte`, plus `frame_err_p` and `parity_err_p` pulses.
- **Top of `wb_ps2_keyboard`:** contains the FIFO, flags and Wishbone logic.

## Test plan
- **Single key:** send frame for 0x1C (parity 0, stop 1) -> STATUS reads count = 1; DATA reads 0x0000011C; the next DATA read returns 0x00000000.
- **Parity error** (`KBD_PARITY_CHECK_EN` defined): send 0x1C with parity = 1 -> count stays 0; STATUS reads 0x00000004; write 0x4 to STATUS, then STATUS reads 0x00000000.
- **Overflow:** send 17 frames 0x01..0x11 with `FIFO_DEPTH` = 16 -> STATUS reads 0x00001001; the 16 DATA reads return 0x101..0x110 in order.
- **Timeout:** send a start bit plus 4 data bits, then idle for `TIMEOUT` + 10 cycles -> `frame_err` = 1, count = 0; the next full frame 0x2A is received correctly.
- **Simultaneous push and pop at full:** with the FIFO full, complete a frame on the same cycle a DATA read is ACKed -> count stays 16, no overflow, new byte at the tail.
- **Reset mid-frame and mid-access:** assert `reset` after 5 bits while STB is high -> next cycle ACK = 0, DAT_O = 0, count = 0, flags = 0; a subsequent frame 0x55 is received normally.
